// File: rtl/flip_candidate_selector_if.sv
// Handshake and data bundle for flip_candidate_selector: candidate-set input side and selection result side.
interface flip_candidate_selector_if #(
    parameter int K    = 3,
    parameter int BW   = 5,
    parameter int IDXW = 2
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [K*BW-1:0] break_values_i;
    logic [K-1:0]    cand_valid_i;
    logic [31:0]     random_i;
    logic            sel_valid_o;
    logic            sel_ready_i;
    logic [IDXW-1:0] select_o;
    logic            select_none_o;
    logic            random_walk_o;
    logic [BW-1:0]   select_break_o;

    modport slave (
        input  in_valid_i, break_values_i, cand_valid_i, random_i, sel_ready_i,
        output in_ready_o, sel_valid_o, select_o, select_none_o, random_walk_o, select_break_o
    );

    modport master (
        output in_valid_i, break_values_i, cand_valid_i, random_i, sel_ready_i,
        input  in_ready_o, sel_valid_o, select_o, select_none_o, random_walk_o, select_break_o
    );
endinterface

// File: rtl/flip_candidate_selector.sv
// Picks a variable to flip from a clause: greedy minimum break value or random walk by rank.
// Optional macro FLIP_SEL_RAND_TIEBREAK_EN: greedy equal-break ties broken by random bits R[16+i].
module flip_candidate_selector #(
    parameter int          K        = 3,
    parameter int          BW       = 5,
    parameter int          IDXW     = 2,
    parameter logic [31:0] P_THRESH = 32'h6E147AE0
) (
    input logic                      clk,
    input logic                      reset,
    flip_candidate_selector_if.slave bus
);
    localparam int CW   = $clog2(K + 1);
    localparam int NPAD = 1 << IDXW;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic [K*BW-1:0] brk_reg, brk_next;
    logic [K-1:0]    valid_reg, valid_next;
    logic [31:0]     rand_reg, rand_next;
    logic            walk_reg, walk_next;
    logic [CW-1:0]   target_reg, target_next;
    logic [CW-1:0]   rank_reg, rank_next;
    logic [IDXW-1:0] best_idx_reg, best_idx_next;
    logic [BW-1:0]   best_brk_reg, best_brk_next;
    logic            have_best_reg, have_best_next;
    logic [IDXW-1:0] select_reg, select_next;
    logic            none_reg, none_next;
    logic            walk_out_reg, walk_out_next;
    logic [BW-1:0]   sel_brk_reg, sel_brk_next;

    // Padded views so the scan index can address them without range issues.
    logic [BW-1:0]   brk_arr [NPAD];
    logic [NPAD-1:0] valid_pad;

    genvar gi;
    generate
        for (gi = 0; gi < NPAD; gi++) begin : g_pad
            if (gi < K) begin : g_live
                assign brk_arr[gi]   = brk_reg[gi*BW +: BW];
                assign valid_pad[gi] = valid_reg[gi];
            end else begin : g_zero
                assign brk_arr[gi]   = '0;
                assign valid_pad[gi] = 1'b0;
            end
        end
    endgenerate

    logic [CW-1:0]      nvalid;
    logic [16+CW-1:0]   prod;
    logic               cur_valid;
    logic [BW-1:0]      cur_brk;
    logic               take;
    logic               tie_take;
    logic               done_now;
    logic [4:0]         tie_bit;

    always_comb begin
        nvalid = '0;
        for (int i = 0; i < K; i++) begin
            nvalid = nvalid + CW'(bus.cand_valid_i[i]);
        end
        prod = {{CW{1'b0}}, bus.random_i[15:0]} * {16'd0, nvalid};
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        brk_next       = brk_reg;
        valid_next     = valid_reg;
        rand_next      = rand_reg;
        walk_next      = walk_reg;
        target_next    = target_reg;
        rank_next      = rank_reg;
        best_idx_next  = best_idx_reg;
        best_brk_next  = best_brk_reg;
        have_best_next = have_best_reg;
        select_next    = select_reg;
        none_next      = none_reg;
        walk_out_next  = walk_out_reg;
        sel_brk_next   = sel_brk_reg;
        cur_valid      = valid_pad[idx_reg];
        cur_brk        = brk_arr[idx_reg];
        take           = 1'b0;
        tie_take       = 1'b0;
        done_now       = 1'b0;
        tie_bit        = 5'd16 + 5'(idx_reg);

        case (state_reg)
            IDLE: begin
                if (bus.in_valid_i) begin
                    brk_next       = bus.break_values_i;
                    valid_next     = bus.cand_valid_i;
                    rand_next      = bus.random_i;
                    walk_next      = bus.random_i > P_THRESH;
                    target_next    = prod[16+CW-1:16];
                    idx_next       = '0;
                    rank_next      = '0;
                    have_best_next = 1'b0;
                    if (nvalid == '0) begin
                        state_next    = DONE;
                        select_next   = '0;
                        none_next     = 1'b1;
                        sel_brk_next  = '0;
                        walk_out_next = bus.random_i > P_THRESH;
                    end else begin
                        state_next = SCAN;
                    end
                end
            end
            SCAN: begin
                if (walk_reg) begin
                    if (cur_valid) begin
                        if (rank_reg == target_reg) begin
                            best_idx_next = idx_reg;
                            best_brk_next = cur_brk;
                        end
                        rank_next = rank_reg + CW'(1);
                    end
                end else if (cur_valid) begin
`ifdef FLIP_SEL_RAND_TIEBREAK_EN
                    tie_take = (cur_brk == best_brk_reg) && rand_reg[tie_bit];
`else
                    tie_take = 1'b0;
`endif
                    take = !have_best_reg || (cur_brk < best_brk_reg) || tie_take;
                    if (take) begin
                        best_idx_next  = idx_reg;
                        best_brk_next  = cur_brk;
                        have_best_next = 1'b1;
                    end
                    // A zero-break flip cannot be beaten, so stop scanning.
                    done_now = (cur_brk == '0);
                end
                if (done_now || idx_reg == IDXW'(K - 1)) begin
                    state_next    = DONE;
                    select_next   = best_idx_next;
                    sel_brk_next  = best_brk_next;
                    none_next     = 1'b0;
                    walk_out_next = walk_reg;
                end else begin
                    idx_next = idx_reg + IDXW'(1);
                end
            end
            DONE: begin
                if (bus.sel_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            brk_reg       <= '0;
            valid_reg     <= '0;
            rand_reg      <= '0;
            walk_reg      <= 1'b0;
            target_reg    <= '0;
            rank_reg      <= '0;
            best_idx_reg  <= '0;
            best_brk_reg  <= '0;
            have_best_reg <= 1'b0;
            select_reg    <= '0;
            none_reg      <= 1'b0;
            walk_out_reg  <= 1'b0;
            sel_brk_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            brk_reg       <= brk_next;
            valid_reg     <= valid_next;
            rand_reg      <= rand_next;
            walk_reg      <= walk_next;
            target_reg    <= target_next;
            rank_reg      <= rank_next;
            best_idx_reg  <= best_idx_next;
            best_brk_reg  <= best_brk_next;
            have_best_reg <= have_best_next;
            select_reg    <= select_next;
            none_reg      <= none_next;
            walk_out_reg  <= walk_out_next;
            sel_brk_reg   <= sel_brk_next;
        end
    end

    assign bus.in_ready_o     = (state_reg == IDLE);
    assign bus.sel_valid_o    = (state_reg == DONE);
    assign bus.select_o       = select_reg;
    assign bus.select_none_o  = none_reg;
    assign bus.random_walk_o  = walk_out_reg;
    assign bus.select_break_o = sel_brk_reg;
endmodule

// File: tb/tb_flip_candidate_selector.sv
// Directed scoreboard bench for flip_candidate_selector (K=3, BW=5, IDXW=2).
module tb_flip_candidate_selector;
    localparam int K = 3, BW = 5, IDXW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    flip_candidate_selector_if #(.K(K), .BW(BW), .IDXW(IDXW)) bus ();

    flip_candidate_selector #(.K(K), .BW(BW), .IDXW(IDXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int sel;
        int none;
        int walk;
        int brk;
        int lat;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Latency = clock edges after the accept edge until sel_valid_o is seen.
    task automatic run(input string tag, input logic [2:0] valid,
                       input int b0, input int b1, input int b2, input logic [31:0] r,
                       input int e_sel, input int e_none, input int e_walk, input int e_brk,
                       input int e_lat, input int hold);
        exp_t e;
        int   lat;
        int   wait_cnt;
        int   s_sel, s_brk;
        wait_cnt = 0;
        while (bus.in_ready_o !== 1'b1 && wait_cnt < 20) begin
            @(posedge clk); #1; wait_cnt++;
        end
        bus.cand_valid_i   = valid;
        bus.break_values_i = {BW'(b2), BW'(b1), BW'(b0)};
        bus.random_i       = r;
        bus.in_valid_i     = 1'b1;
        e.sel = e_sel; e.none = e_none; e.walk = e_walk; e.brk = e_brk; e.lat = e_lat;
        q.push_back(e);
        @(posedge clk); #1;
        // Garbage inputs while busy must be ignored.
        bus.cand_valid_i   = '1;
        bus.break_values_i = '0;
        bus.random_i       = $urandom;
        lat = 0;
        while (bus.sel_valid_o !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        e = q.pop_front();
        check({tag, ".lat"},  lat, e.lat);
        check({tag, ".sel"},  int'(bus.select_o), e.sel);
        check({tag, ".none"}, int'(bus.select_none_o), e.none);
        check({tag, ".walk"}, int'(bus.random_walk_o), e.walk);
        check({tag, ".brk"},  int'(bus.select_break_o), e.brk);
        check({tag, ".rdy"},  int'(bus.in_ready_o), 0);
        s_sel = int'(bus.select_o);
        s_brk = int'(bus.select_break_o);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_v"},   int'(bus.sel_valid_o), 1);
            check({tag, ".hold_sel"}, int'(bus.select_o), s_sel);
            check({tag, ".hold_brk"}, int'(bus.select_break_o), s_brk);
            check({tag, ".hold_rdy"}, int'(bus.in_ready_o), 0);
        end
        bus.in_valid_i  = 1'b0;
        bus.sel_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.sel_ready_i = 1'b0;
        check({tag, ".release_v"},   int'(bus.sel_valid_o), 0);
        check({tag, ".release_rdy"}, int'(bus.in_ready_o), 1);
        $display("txn %s: sel=%0d none=%0d walk=%0d brk=%0d lat=%0d", tag,
                 bus.select_o, bus.select_none_o, bus.random_walk_o, bus.select_break_o, lat);
    endtask

    initial begin
        int tie_sel;
        bus.in_valid_i = 1'b0;
        bus.sel_ready_i = 1'b0;
        bus.cand_valid_i = '0;
        bus.break_values_i = '0;
        bus.random_i = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready",  int'(bus.in_ready_o), 1);
        check("rst.sel_valid", int'(bus.sel_valid_o), 0);
        check("rst.select",    int'(bus.select_o), 0);
        check("rst.none",      int'(bus.select_none_o), 0);
        check("rst.walk",      int'(bus.random_walk_o), 0);
        check("rst.brk",       int'(bus.select_break_o), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run("zero_idx1",   3'b111, 2, 0, 1, 32'h0,        1, 0, 0, 0, 2, 0);
        run("skip_idx1",   3'b101, 3, 0, 1, 32'h0,        2, 0, 0, 1, 3, 0);
        run("none_walk",   3'b000, 7, 7, 7, 32'hFFFFFFFF, 0, 1, 1, 0, 0, 0);
        run("none_greedy", 3'b000, 7, 7, 7, 32'h0,        0, 1, 0, 0, 0, 0);
        run("walk_t1",     3'b111, 4, 4, 4, 32'hFFFF8000, 1, 0, 1, 4, 3, 0);
`ifdef FLIP_SEL_RAND_TIEBREAK_EN
        tie_sel = 2;
`else
        tie_sel = 0;
`endif
        run("tie",         3'b111, 4, 4, 4, 32'h00050000, tie_sel, 0, 0, 4, 3, 0);
        run("zero_idx0",   3'b111, 0, 3, 3, 32'h0,        0, 0, 0, 0, 1, 0);
        run("greedy_min",  3'b111, 5, 2, 3, 32'h0,        1, 0, 0, 2, 3, 5);
        run("walk_t2",     3'b111, 1, 0, 7, 32'hFFFFFFFF, 2, 0, 1, 7, 3, 0);
        run("walk_rank",   3'b110, 9, 3, 6, 32'hFFFF0000, 1, 0, 1, 3, 3, 0);

        // Abort a set mid-scan with reset; no result may appear for it.
        bus.cand_valid_i   = 3'b111;
        bus.break_values_i = {5'd3, 5'd3, 5'd3};
        bus.random_i       = 32'h0;
        bus.in_valid_i     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort.in_ready",  int'(bus.in_ready_o), 1);
        check("abort.sel_valid", int'(bus.sel_valid_o), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort.quiet", int'(bus.sel_valid_o), 0);
        end
        $display("txn abort: reset mid-scan, sel_valid=%0d", bus.sel_valid_o);

        run("after_abort", 3'b011, 6, 1, 0, 32'h0,        1, 0, 0, 1, 3, 0);
        check("sb.empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
